// File: rtl/riscv_mdu_if.sv
// riscv_mdu_if: request/response bundle between the execute stage and the MDU.
//   start_i      request strobe (master -> mdu)
//   op_i         3-bit MDU opcode (master -> mdu)
//   op_a_i       rs1 value: multiplicand / dividend (master -> mdu)
//   op_b_i       rs2 value: multiplier / divisor (master -> mdu)
//   busy_o       unit occupied, pipeline must stall (mdu -> master)
//   valid_o      one-cycle result strobe (mdu -> master)
//   result_o     32-bit result, held until the next valid_o (mdu -> master)
interface riscv_mdu_if #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned MDU_OP_WIDTH = 3
);
  logic                    start_i;
  logic [MDU_OP_WIDTH-1:0] op_i;
  logic [WORD_WIDTH-1:0]   op_a_i;
  logic [WORD_WIDTH-1:0]   op_b_i;
  logic                    busy_o;
  logic                    valid_o;
  logic [WORD_WIDTH-1:0]   result_o;

  modport master (
    output start_i, op_i, op_a_i, op_b_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, op_a_i, op_b_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M multiply/divide unit.
//   clk   core clock, rising edge
//   rst   synchronous active-high reset
//   bus   riscv_mdu_if.slave: start_i/op_i/op_a_i/op_b_i in, busy_o/valid_o/result_o out
// Multiplies use 32-step shift-add, divides 32-step restoring division, both on
// unsigned magnitudes with the sign fixed up on the way into DONE. Divide by zero
// and signed overflow are resolved at acceptance and skip the iteration.
// Optional macro RISCV_MDU_FAST_MUL_EN: multiplies complete in one cycle through
// a 33x33 signed multiplier; division is unaffected.
module riscv_mdu #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned MDU_OP_WIDTH = 3
) (
  input logic        clk,
  input logic        rst,
  riscv_mdu_if.slave bus
);

  localparam logic [MDU_OP_WIDTH-1:0] OpMul    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] OpMulh   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] OpMulhsu = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] OpDiv    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] OpRem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic [WORD_WIDTH-1:0]   a_mag_q;
  logic [WORD_WIDTH-1:0]   b_mag_q;
  logic                    neg_q;
  logic [4:0]              cnt_q;
  // Multiply: {hi, lo} with lo preloaded with the multiplier.
  // Divide: low half is the dividend shifting out / quotient shifting in.
  logic [2*WORD_WIDTH-1:0] acc_q;
  logic [WORD_WIDTH-1:0]   rem_q;
  logic                    busy_q;
  logic                    valid_q;
  logic [WORD_WIDTH-1:0]   result_q;

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

  // Acceptance-cycle decode
  logic                  in_is_div;
  logic                  in_a_signed;
  logic                  in_b_signed;
  logic                  in_a_neg;
  logic                  in_b_neg;
  logic [WORD_WIDTH-1:0] in_a_abs;
  logic [WORD_WIDTH-1:0] in_b_abs;
  logic                  in_div_zero;
  logic                  in_div_ovf;
  logic                  in_special;
  logic [WORD_WIDTH-1:0] in_special_res;
  logic                  in_neg;

  always_comb begin
    in_is_div   = bus.op_i[2];
    in_a_signed = (bus.op_i == OpMulh) || (bus.op_i == OpMulhsu) ||
                  (bus.op_i == OpDiv)  || (bus.op_i == OpRem);
    in_b_signed = (bus.op_i == OpMulh) || (bus.op_i == OpDiv) || (bus.op_i == OpRem);
    in_a_neg    = in_a_signed & bus.op_a_i[WORD_WIDTH-1];
    in_b_neg    = in_b_signed & bus.op_b_i[WORD_WIDTH-1];
    in_a_abs    = in_a_neg ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
    in_b_abs    = in_b_neg ? (~bus.op_b_i + 1'b1) : bus.op_b_i;
    in_div_zero = in_is_div && (bus.op_b_i == '0);
    in_div_ovf  = ((bus.op_i == OpDiv) || (bus.op_i == OpRem)) &&
                  (bus.op_a_i == 32'h8000_0000) && (bus.op_b_i == 32'hFFFF_FFFF);
    in_special  = in_div_zero || in_div_ovf;
    // op_i[1] separates REM/REMU from DIV/DIVU
    if (in_div_zero) begin
      in_special_res = bus.op_i[1] ? bus.op_a_i : '1;
    end else begin
      in_special_res = bus.op_i[1] ? '0 : 32'h8000_0000;
    end
    // Remainder follows the dividend; product and quotient use the XOR.
    in_neg = (in_is_div && bus.op_i[1]) ? in_a_neg : (in_a_neg ^ in_b_neg);
  end

`ifdef RISCV_MDU_FAST_MUL_EN
  logic [2*WORD_WIDTH-1:0] fast_prod;
  logic [WORD_WIDTH-1:0]   fast_res;

  always_comb begin
    // 33-bit signed operands, evaluated in 64 bits; only the low 64 bits matter.
    fast_prod = {{WORD_WIDTH{in_a_signed & bus.op_a_i[WORD_WIDTH-1]}}, bus.op_a_i} *
                {{WORD_WIDTH{in_b_signed & bus.op_b_i[WORD_WIDTH-1]}}, bus.op_b_i};
    fast_res  = (bus.op_i == OpMul) ? fast_prod[WORD_WIDTH-1:0]
                                    : fast_prod[2*WORD_WIDTH-1:WORD_WIDTH];
  end
`endif

  // One iteration step of each datapath
  logic [WORD_WIDTH:0]     mul_sum;
  logic [2*WORD_WIDTH-1:0] mul_next;
  logic [2*WORD_WIDTH-1:0] mul_signed;
  logic [WORD_WIDTH-1:0]   mul_res;
  logic [WORD_WIDTH:0]     div_shift;
  logic [WORD_WIDTH:0]     div_trial;
  logic [WORD_WIDTH-1:0]   div_rem_next;
  logic [WORD_WIDTH-1:0]   div_quo_next;
  logic [WORD_WIDTH-1:0]   div_mag;
  logic [WORD_WIDTH-1:0]   div_res;
  logic [WORD_WIDTH-1:0]   calc_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WORD_WIDTH-1:WORD_WIDTH]} +
               (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next = {mul_sum, acc_q[WORD_WIDTH-1:1]};

    // 33-bit partial remainder; a set top bit of the trial means "restore".
    div_shift    = {rem_q, acc_q[WORD_WIDTH-1]};
    div_trial    = div_shift - {1'b0, b_mag_q};
    div_rem_next = div_trial[WORD_WIDTH] ? div_shift[WORD_WIDTH-1:0]
                                         : div_trial[WORD_WIDTH-1:0];
    div_quo_next = {acc_q[WORD_WIDTH-2:0], ~div_trial[WORD_WIDTH]};

    // Final-step results, used on the edge that enters DONE
    mul_signed = neg_q ? (~mul_next + 1'b1) : mul_next;
    mul_res    = (op_q == OpMul) ? mul_signed[WORD_WIDTH-1:0]
                                 : mul_signed[2*WORD_WIDTH-1:WORD_WIDTH];
    div_mag    = op_q[1] ? div_rem_next : div_quo_next;
    div_res    = neg_q ? (~div_mag + 1'b1) : div_mag;
    calc_res   = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            op_q    <= bus.op_i;
            a_mag_q <= in_a_abs;
            b_mag_q <= in_b_abs;
            neg_q   <= in_neg;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= {{WORD_WIDTH{1'b0}}, (in_is_div ? in_a_abs : in_b_abs)};
            busy_q  <= 1'b1;
            if (in_special) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= in_special_res;
`ifdef RISCV_MDU_FAST_MUL_EN
            end else if (!in_is_div) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= fast_res;
`endif
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= op_q[2] ? {{WORD_WIDTH{1'b0}}, div_quo_next} : mul_next;
          rem_q <= div_rem_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= StDone;
            valid_q  <= 1'b1;
            result_q <= calc_res;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu: scoreboard bench for riscv_mdu. Requests push the expected
// result and latency from an arithmetic reference model; a negedge monitor
// checks busy_o every cycle and pops/compares on every valid_o.
module tb_riscv_mdu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  riscv_mdu_if bus ();

  riscv_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
    logic [2:0]  op;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit / 32-bit arithmetic on the architectural rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RISCV_MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      exp_busy = 1'b0;
      if (exp_q.size() != 0)
        exp_busy = (cyc >= exp_q[0].t0 + 1) && (cyc <= exp_q[0].t0 + exp_q[0].lat);
      chk("busy", {31'd0, bus.busy_o}, {31'd0, exp_busy});
      if (bus.valid_o) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %h, expected no valid (cycle %0d)",
                   bus.result_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("result op%0d", e.op), bus.result_o, e.res);
          chk($sformatf("latency op%0d", e.op), 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy for %0d cycles, expected idle", n);
    end
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    e.res = model(op, a, b);
    e.t0  = cyc;
    e.lat = latency(op, a, b);
    e.op  = op;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_a_i  = $urandom;
    bus.op_b_i  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD},
    '{3'd1, 32'h8000_0000,  32'h8000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2},
    '{3'd6, 32'hFFFF_FFF9,  32'd2},
    '{3'd5, 32'd100,        32'd7},
    '{3'd7, 32'd100,        32'd7},
    '{3'd5, 32'd5,          32'd0},
    '{3'd7, 32'd5,          32'd0},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF}
  };

  initial begin
    int v0;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy",   {31'd0, bus.busy_o},  32'd0);
    chk("reset valid",  {31'd0, bus.valid_o}, 32'd0);
    chk("reset result", bus.result_o,         32'd0);
    rst = 1'b0;

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b);
    drain();

    for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
    drain();

    // start_i pulse during CALC must be ignored
    v0 = nvalid;
    issue(3'd5, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.op_a_i  = 32'd9;
    bus.op_b_i  = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("single valid on ignored start", 32'(nvalid - v0), 32'd1);

    // Reset in cycle 10 of a DIV aborts it
    issue(3'd4, 32'hFFFF_FF00, 32'd5);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    v0 = nvalid;
    @(negedge clk);
    chk("abort busy",   {31'd0, bus.busy_o},  32'd0);
    chk("abort valid",  {31'd0, bus.valid_o}, 32'd0);
    chk("abort result", bus.result_o,         32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no valid after abort", 32'(nvalid - v0), 32'd0);

    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
